// File: rtl/inst_queue.sv
// Circular instruction queue sitting between fetch and decode.
// Fetch pushes up to FETCH_W instructions per cycle into consecutive slots
// starting at the tail. Decode sees the ISSUE_W oldest entries starting at the
// head and consumes up to ISSUE_W of them per cycle. A flush either empties the
// queue or keeps only the oldest entry, which holds a branch delay slot.
module inst_queue #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DATA_W  = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           flush_keep1,
    input  logic                           push_valid,
    input  logic [$clog2(FETCH_W+1)-1:0]   push_num,
    input  logic [FETCH_W*DATA_W-1:0]      push_data,
    output logic                           push_ready,
    output logic [ISSUE_W-1:0]             out_valid,
    output logic [ISSUE_W*DATA_W-1:0]      out_data,
    input  logic [$clog2(ISSUE_W+1)-1:0]   pop_num,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           empty,
    output logic                           full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_fire;
    logic [CNT_W-1:0] push_amt;
    logic [CNT_W-1:0] pop_amt;
    logic [CNT_W-1:0] avail;

    // Accepted push and clamped pop amounts; flush suppresses both.
    always_comb begin
        push_amt  = '0;
        pop_amt   = '0;
        avail     = (count_q < CNT_W'(ISSUE_W)) ? count_q : CNT_W'(ISSUE_W);
        push_fire = push_valid && push_ready && !flush;
        if (push_fire) begin
            push_amt = (CNT_W'(push_num) > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W)
                                                            : CNT_W'(push_num);
        end
        if (!flush) begin
            pop_amt = (CNT_W'(pop_num) > avail) ? avail : CNT_W'(pop_num);
        end
    end

    // Next pointer/occupancy state; a flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            if (flush_keep1 && (count_q != '0)) begin
                tail_d  = head_q + PTR_W'(1);
                count_d = CNT_W'(1);
            end else begin
                tail_d  = head_q;
                count_d = '0;
            end
        end else begin
            head_d  = head_q + PTR_W'(pop_amt);
            tail_d  = tail_q + PTR_W'(push_amt);
            count_d = count_q + push_amt - pop_amt;
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage: accepted lanes land in consecutive slots from the tail.
    always_ff @(posedge clk) begin
        for (int l = 0; l < FETCH_W; l++) begin
            if (push_fire && (CNT_W'(l) < push_amt)) begin
                mem_q[tail_q + PTR_W'(l)] <= push_data[l*DATA_W +: DATA_W];
            end
        end
    end

    // Issue lanes expose the oldest entries; a flush hides them immediately.
    generate
        for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_lane
            assign out_valid[gi]                   = (count_q > CNT_W'(gi)) && !flush;
            assign out_data[gi*DATA_W +: DATA_W]   = mem_q[head_q + PTR_W'(gi)];
        end
    endgenerate

    // Readiness counts only current occupancy; no credit for a same-cycle pop.
    assign push_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_inst_queue;

    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int DATA_W  = 64;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         flush;
    logic                         flush_keep1;
    logic                         push_valid;
    logic [1:0]                   push_num;
    logic [FETCH_W*DATA_W-1:0]    push_data;
    logic                         push_ready;
    logic [ISSUE_W-1:0]           out_valid;
    logic [ISSUE_W*DATA_W-1:0]    out_data;
    logic [1:0]                   pop_num;
    logic [3:0]                   count;
    logic                         empty;
    logic                         full;

    logic [DATA_W-1:0] model[$];
    int vectors     = 0;
    int miscompares = 0;
    logic [DATA_W-1:0] seq_val;

    always #5 clk = ~clk;

    inst_queue #(
        .DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_keep1(flush_keep1),
        .push_valid(push_valid), .push_num(push_num), .push_data(push_data),
        .push_ready(push_ready), .out_valid(out_valid), .out_data(out_data),
        .pop_num(pop_num), .count(count), .empty(empty), .full(full)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every observable output with what the model's contents imply.
    task automatic check_outputs(input string ph);
        int sz;
        logic [1:0] ev;
        sz = model.size();
        ev = '0;
        for (int i = 0; i < ISSUE_W; i++) ev[i] = (sz > i) && !flush;
        check_eq({ph, ".count"}, 64'(count), 64'(sz));
        check_eq({ph, ".empty"}, 64'(empty), 64'(sz == 0));
        check_eq({ph, ".full"}, 64'(full), 64'(sz == DEPTH));
        check_eq({ph, ".push_ready"}, 64'(push_ready), 64'((DEPTH - sz) >= FETCH_W));
        check_eq({ph, ".out_valid"}, 64'(out_valid), 64'(ev));
        for (int i = 0; i < ISSUE_W; i++) begin
            if (ev[i]) check_eq($sformatf("%s.lane%0d", ph, i),
                                out_data[i*DATA_W +: DATA_W], model[i]);
        end
    endtask

    // One transaction: drive inputs, check outputs, advance the model, clock.
    task automatic step(input string ph, input bit pv, input int pn,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input int pp, input bit fl, input bit k1);
        int sz;
        int npop;
        bit rdy;
        logic [63:0] lanes [2];
        @(negedge clk);
        push_valid  = pv;
        push_num    = 2'(pn);
        push_data   = {d1, d0};
        pop_num     = 2'(pp);
        flush       = fl;
        flush_keep1 = k1;
        #1;
        check_outputs(ph);
        $display("%s: pv=%0d pn=%0d pop=%0d fl=%0d k1=%0d count=%0d", ph, pv, pn, pp, fl, k1, count);
        lanes[0] = d0;
        lanes[1] = d1;
        sz  = model.size();
        rdy = (DEPTH - sz) >= FETCH_W;
        if (fl) begin
            if (k1 && sz >= 1) begin
                while (model.size() > 1) void'(model.pop_back());
            end else begin
                model.delete();
            end
        end else begin
            npop = (pp < sz) ? pp : sz;
            if (npop > ISSUE_W) npop = ISSUE_W;
            for (int i = 0; i < npop; i++) void'(model.pop_front());
            if (pv && rdy) begin
                for (int i = 0; i < pn; i++) model.push_back(lanes[i]);
            end
        end
    endtask

    task automatic idle_step(input string ph);
        step(ph, 0, 0, 64'h0, 64'h0, 0, 0, 0);
    endtask

    task automatic drain(input string ph);
        for (int i = 0; i < 8 && model.size() > 0; i++) step(ph, 0, 0, 64'h0, 64'h0, 2, 0, 0);
    endtask

    task automatic fill_to(input string ph, input int n);
        while (model.size() < n) begin
            step(ph, 1, 1, {$urandom, $urandom}, 64'h0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 0; flush_keep1 = 0; push_valid = 0;
        push_num = 0; push_data = '0; pop_num = 0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fill two per cycle, then an extra push that must be refused.
        for (int i = 0; i < 5; i++) step("fill", 1, 2, 64'(100 + 2*i), 64'(101 + 2*i), 0, 0, 0);
        idle_step("fill_hold");
        drain("fill_drain");

        // Odd fill: seven singles leave one free slot, not enough to accept.
        for (int i = 0; i < 7; i++) step("odd", 1, 1, 64'(200 + i), 64'h0, 0, 0, 0);
        step("odd_pop", 0, 0, 64'h0, 64'h0, 1, 0, 0);
        idle_step("odd_after");
        drain("odd_drain");

        // Ordered stream across the pointer wrap with concurrent pops.
        seq_val = 64'h10;
        for (int i = 0; i < 8; i++) begin
            step("wrap", 1, 2, seq_val, seq_val + 1, 2, 0, 0);
            seq_val = seq_val + 2;
        end
        drain("wrap_drain");

        // Simultaneous push 2 / pop 2 at count 6, then pop overshoot at count 1.
        fill_to("sim_fill", 6);
        step("sim_pp", 1, 2, 64'hA0, 64'hA1, 2, 0, 0);
        idle_step("sim_after");
        drain("sim_drain");
        fill_to("ovr_fill", 1);
        step("ovr_pop", 0, 0, 64'h0, 64'h0, 2, 0, 0);
        idle_step("ovr_after");

        // Full flush with a competing push, then keep-one flush.
        fill_to("fl_fill", 5);
        step("flush", 1, 2, 64'hB0, 64'hB1, 2, 1, 0);
        idle_step("flush_after");
        fill_to("k1_fill", 5);
        step("flush_k1", 1, 2, 64'hC0, 64'hC1, 2, 1, 1);
        idle_step("k1_after");
        step("k1_empty", 0, 0, 64'h0, 64'h0, 1, 0, 0);
        step("k1_zero", 0, 0, 64'h0, 64'h0, 0, 1, 1);
        idle_step("k1_zero_after");

        // Reset dropped mid-push at count 4.
        fill_to("rst_fill", 4);
        @(negedge clk);
        push_valid = 1; push_num = 2; push_data = {64'hD1, 64'hD0};
        pop_num = 0; flush = 0; flush_keep1 = 0;
        #2;
        reset = 1'b0;
        #1;
        model.delete();
        check_outputs("rst_mid");
        push_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        step("rst_push", 1, 2, 64'hAAAA, 64'hBBBB, 0, 0, 0);
        idle_step("rst_after");
        drain("rst_drain");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit fl;
            fl = ($urandom_range(0, 15) == 0);
            step("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), fl, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
